// File: rtl/instr_fetch_controller.sv
// Instruction fetch controller: drives the combinational instruction ROM from
// a fetch PC, buffers returned words in a small prefetch queue and hands them
// to decode over a valid/ready handshake. Redirects flush the queue; a
// misaligned redirect target parks the fetcher in a sticky FAULT state.
module instr_fetch_controller #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          QUEUE_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        fetch_enable,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] mem_address,
  input  logic [31:0] mem_readdata,
  output logic        instr_valid,
  output logic [31:0] instr_data,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  output logic        fault,
  output logic [31:0] fault_pc,
  output logic [31:0] retired_count
);

  localparam int CW = $clog2(QUEUE_DEPTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FAULT
  } state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } entry_t;

  state_t        r_state;
  state_t        w_state_nxt;
  entry_t        r_queue [QUEUE_DEPTH];
  logic [CW-1:0] r_count;
  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_fault_pc;
  logic [31:0]   r_retired;
  logic          r_fault;

  logic          w_pop;
  logic          w_push;
  logic          w_full;
  logic          w_aligned;
  logic [CW-1:0] w_wr_idx;

  // Handshake and queue bookkeeping. A pop frees a slot in the same cycle, so
  // a full queue can still accept a push while the head is consumed.
  assign w_pop     = instr_valid && instr_ready;
  assign w_full    = (r_count == CW'(QUEUE_DEPTH));
  assign w_aligned = (redirect_pc[1:0] == 2'b00);
  assign w_push    = (r_state == S_RUN) && !redirect_valid && (!w_full || w_pop);
  assign w_wr_idx  = r_count - CW'(w_pop);

  // Next-state logic; a redirect overrides every state, FAULT ignores fetch_enable.
  always_comb begin
    // NOTE: every signal assigned in a combinational block gets a default
    // first, so no path can leave it unassigned and infer a latch.
    w_state_nxt = r_state;
    if (redirect_valid) begin
      if (w_aligned) w_state_nxt = fetch_enable ? S_RUN : S_IDLE;
      else           w_state_nxt = S_FAULT;
    end else begin
      case (r_state)
        S_IDLE:  if (fetch_enable)  w_state_nxt = S_RUN;
        S_RUN:   if (!fetch_enable) w_state_nxt = S_IDLE;
        S_FAULT: w_state_nxt = S_FAULT;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Fetch PC, fault capture and retirement counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_fetch_pc <= RESET_PC;
      r_fault    <= 1'b0;
      r_fault_pc <= '0;
      r_retired  <= '0;
    end else begin
      if (w_pop) r_retired <= r_retired + 32'd1;
      if (redirect_valid) begin
        if (w_aligned) begin
          r_fetch_pc <= redirect_pc;
          r_fault    <= 1'b0;
        end else begin
          r_fault    <= 1'b1;
          r_fault_pc <= redirect_pc;
        end
      end else if (w_push) begin
        r_fetch_pc <= r_fetch_pc + 32'd4;
      end
    end
  end

  // Prefetch queue: entry 0 is the head; pops shift toward it, pushes land at
  // the first free slot after the shift. A redirect only clears the occupancy.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
      // NOTE: the queue storage is reset too, because the head entry drives
      // instr_data/instr_pc directly and those must read zero out of reset.
      for (int i = 0; i < QUEUE_DEPTH; i++) r_queue[i] <= '0;
    end else if (redirect_valid) begin
      r_count <= '0;
    end else begin
      if (w_pop) begin
        for (int i = 0; i < QUEUE_DEPTH - 1; i++) r_queue[i] <= r_queue[i+1];
      end
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        if (w_push && (CW'(i) == w_wr_idx)) begin
          r_queue[i] <= '{pc: r_fetch_pc, data: mem_readdata};
        end
      end
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  assign mem_address   = r_fetch_pc;
  assign instr_valid   = (r_count != '0);
  assign instr_data    = r_queue[0].data;
  assign instr_pc      = r_queue[0].pc;
  assign fault         = r_fault;
  assign fault_pc      = r_fault_pc;
  assign retired_count = r_retired;

endmodule

// File: tb/tb_instr_fetch_controller.sv
// Bench for instr_fetch_controller: directed stimulus with a scoreboard queue
// of expected (pc, data) deliveries, consumed by an independent monitor.
module tb_instr_fetch_controller;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } exp_t;

  logic        clk;
  logic        reset_n;
  logic        fetch_enable;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] mem_address;
  logic [31:0] mem_readdata;
  logic        instr_valid;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic        fault;
  logic [31:0] fault_pc;
  logic [31:0] retired_count;

  int   n_cmp = 0;
  int   n_err = 0;
  exp_t exp_q[$];

  // Big-endian byte ROM: bytes 0..7 hold two instructions, everything else 0.
  logic [7:0] rom_bytes [0:7];
  logic [2:0] rom_a;
  assign rom_a = mem_address[2:0];
  assign mem_readdata = (mem_address < 32'd8) ?
      {rom_bytes[rom_a], rom_bytes[rom_a + 3'd1], rom_bytes[rom_a + 3'd2], rom_bytes[rom_a + 3'd3]} :
      32'h0;

  instr_fetch_controller #(
    .RESET_PC    (32'h0),
    .QUEUE_DEPTH (2)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .fetch_enable   (fetch_enable),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .mem_address    (mem_address),
    .mem_readdata   (mem_readdata),
    .instr_valid    (instr_valid),
    .instr_data     (instr_data),
    .instr_pc       (instr_pc),
    .instr_ready    (instr_ready),
    .fault          (fault),
    .fault_pc       (fault_pc),
    .retired_count  (retired_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_instr(input logic [31:0] pc, input logic [31:0] data);
    exp_q.push_back('{pc: pc, data: data});
  endtask

  // Monitor: every accepted instruction must match the next scoreboard entry.
  always @(negedge clk) begin
    if (reset_n && instr_valid && instr_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_delivery: got pc %h data %h expected none", instr_pc, instr_data);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("deliver_pc", instr_pc, e.pc);
        check("deliver_data", instr_data, e.data);
      end
    end
  end

  initial begin
    rom_bytes = '{8'hAC, 8'h41, 8'h00, 8'h0A, 8'h8C, 8'h43, 8'h00, 8'h0A};
    reset_n        = 1'b0;
    fetch_enable   = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    instr_ready    = 1'b0;

    // Reset values.
    repeat (2) tick();
    check("rst_valid", {31'b0, instr_valid}, 32'd0);
    check("rst_data", instr_data, 32'h0);
    check("rst_pc", instr_pc, 32'h0);
    check("rst_fault", {31'b0, fault}, 32'd0);
    check("rst_fault_pc", fault_pc, 32'h0);
    check("rst_retired", retired_count, 32'd0);
    check("rst_mem_addr", mem_address, 32'h0);

    // Streaming from reset: valid two edges after enable, one pop per cycle.
    reset_n      = 1'b1;
    fetch_enable = 1'b1;
    instr_ready  = 1'b1;
    expect_instr(32'h0, 32'hAC41000A);
    expect_instr(32'h4, 32'h8C43000A);
    expect_instr(32'h8, 32'h00000000);
    tick();
    check("start_valid_lo", {31'b0, instr_valid}, 32'd0);
    tick();
    check("start_valid_hi", {31'b0, instr_valid}, 32'd1);
    for (int k = 1; k <= 3; k++) begin
      tick();
      check("stream_retired", retired_count, 32'(k));
    end

    // Flush with an aligned redirect to 0, then backpressure for 5 cycles.
    instr_ready    = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0;
    tick();
    redirect_valid = 1'b0;
    check("redir0_gap", {31'b0, instr_valid}, 32'd0);
    tick();
    check("bp_valid", {31'b0, instr_valid}, 32'd1);
    check("bp_head_pc", instr_pc, 32'h0);
    check("bp_head_data", instr_data, 32'hAC41000A);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("bp_hold_pc", instr_pc, 32'h0);
      check("bp_hold_data", instr_data, 32'hAC41000A);
    end
    check("bp_fetch_pc", mem_address, 32'h8);

    // Release: 0, 4, 8 in order; redirect to 4 while 8 and 12 are queued,
    // with the pop of 8 landing on the redirect edge.
    expect_instr(32'h0, 32'hAC41000A);
    expect_instr(32'h4, 32'h8C43000A);
    expect_instr(32'h8, 32'h00000000);
    instr_ready = 1'b1;
    repeat (2) tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h4;
    expect_instr(32'h4, 32'h8C43000A);
    expect_instr(32'h8, 32'h00000000);
    tick();
    redirect_valid = 1'b0;
    check("redir4_gap", {31'b0, instr_valid}, 32'd0);
    check("redir4_retired", retired_count, 32'd6);
    tick();
    check("redir4_head_pc", instr_pc, 32'h4);
    repeat (2) tick();
    instr_ready = 1'b0;
    check("redir4_retired2", retired_count, 32'd8);

    // Misaligned redirect: sticky fault, no pushes even with fetch_enable high.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h6;
    tick();
    redirect_valid = 1'b0;
    instr_ready    = 1'b1;
    check("fault_pc", fault_pc, 32'h6);
    check("fault_mem_addr", mem_address, 32'h10);
    for (int k = 0; k < 10; k++) begin
      tick();
      check("fault_set", {31'b0, fault}, 32'd1);
      check("fault_no_valid", {31'b0, instr_valid}, 32'd0);
    end
    check("fault_pc_held", mem_address, 32'h10);
    expect_instr(32'h0, 32'hAC41000A);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0;
    tick();
    redirect_valid = 1'b0;
    check("fault_cleared", {31'b0, fault}, 32'd0);
    check("fault_exit_gap", {31'b0, instr_valid}, 32'd0);
    repeat (2) tick();
    instr_ready = 1'b0;
    check("fault_exit_retired", retired_count, 32'd9);

    // Wrap: FFFFFFFC then 00000000.
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    expect_instr(32'hFFFF_FFFC, 32'h00000000);
    expect_instr(32'h0000_0000, 32'hAC41000A);
    tick();
    redirect_valid = 1'b0;
    instr_ready    = 1'b1;
    check("wrap_mem_addr", mem_address, 32'hFFFF_FFFC);
    check("wrap_gap", {31'b0, instr_valid}, 32'd0);
    repeat (3) tick();
    instr_ready = 1'b0;
    check("wrap_retired", retired_count, 32'd11);

    // Drop fetch_enable with the queue full: drain, then no more pushes.
    tick();
    fetch_enable = 1'b0;
    tick();
    check("gate_fetch_pc", mem_address, 32'hC);
    expect_instr(32'h4, 32'h8C43000A);
    expect_instr(32'h8, 32'h00000000);
    instr_ready = 1'b1;
    repeat (2) tick();
    check("gate_drained", {31'b0, instr_valid}, 32'd0);
    check("gate_retired", retired_count, 32'd13);
    for (int k = 0; k < 2; k++) begin
      tick();
      check("gate_no_push", {31'b0, instr_valid}, 32'd0);
      check("gate_pc_hold", mem_address, 32'hC);
    end

    // Resume, then pulse reset mid-stream.
    fetch_enable = 1'b1;
    expect_instr(32'hC, 32'h00000000);
    expect_instr(32'h10, 32'h00000000);
    repeat (4) tick();
    check("resume_retired", retired_count, 32'd15);
    reset_n = 1'b0;
    #1;
    check("mid_rst_valid", {31'b0, instr_valid}, 32'd0);
    check("mid_rst_data", instr_data, 32'h0);
    check("mid_rst_pc", instr_pc, 32'h0);
    check("mid_rst_retired", retired_count, 32'd0);
    check("mid_rst_mem_addr", mem_address, 32'h0);
    check("mid_rst_fault", {31'b0, fault}, 32'd0);
    tick();
    reset_n = 1'b1;
    fetch_enable = 1'b0;
    tick();
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/instr_fetch_controller.md
Name: instr_fetch_controller

Overview:
- Sequences the combinational Harvard instruction ROM on behalf of the CPU core.
- Holds the fetch PC and drives the ROM address each cycle.
- Captures the returned big-endian 32-bit word into a small prefetch queue and presents it to the decode stage over a valid/ready handshake.
- Handles branch redirects (queue flush), fetch gating, and a misaligned-target fault state.

Parameters:
- RESET_PC, 32'h00000000, fetch PC loaded on reset; bits [1:0] must be 0.
- QUEUE_DEPTH, 2, prefetch queue entries; legal values 1..4.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- fetch_enable  input  1  permits fetching; low holds fetch, queue keeps draining.
- redirect_valid  input  1  load new fetch PC and flush queue this cycle.
- redirect_pc  input  32  redirect target byte address.
- mem_address  output  32  byte address to instruction ROM (combinational from fetch PC).
- mem_readdata  input  32  ROM word at mem_address, valid same cycle.
- instr_valid  output  1  queue head holds a valid instruction.
- instr_data  output  32  queue head instruction word.
- instr_pc  output  32  byte address of instr_data.
- instr_ready  input  1  consumer accepts head this cycle.
- fault  output  1  misaligned redirect target captured; sticky.
- fault_pc  output  32  offending redirect_pc.
- retired_count  output  32  count of accepted instructions (valid&&ready), wraps.

Behaviour:
- Reset (async assert, sync-released by the system):
  - state=IDLE, fetch_pc=RESET_PC, queue empty.
  - instr_valid=0, instr_data=0, instr_pc=0.
  - fault=0, fault_pc=0, retired_count=0.
- mem_address = fetch_pc at all times, including IDLE and FAULT.
- States:
  - IDLE: no push. fetch_enable=1 -> RUN.
  - RUN: push when queue not full OR a pop occurs this cycle. fetch_enable=0 -> IDLE.
  - FAULT: no push. fault=1.
- Push (RUN only):
  - Entry {fetch_pc, mem_readdata} written to queue tail; fetch_pc <= fetch_pc+4, modulo 2^32.
  - 32'hFFFFFFFC wraps to 32'h00000000.
- Pop: instr_valid && instr_ready. Head advances; retired_count += 1.
- Simultaneous push and pop: both occur; occupancy unchanged. This includes the full case.
- Queue full and no pop: no push; fetch_pc holds.
- Redirect (redirect_valid=1, any state), highest priority:
  - Queue flushed, pending push discarded.
  - A pop at the same edge still counts if instr_valid && instr_ready.
  - redirect_pc[1:0]==0:
    - fetch_pc <= redirect_pc.
    - State -> RUN if fetch_enable, else IDLE.
    - fault cleared.
  - redirect_pc[1:0]!=0:
    - State -> FAULT, fault_pc <= redirect_pc, fetch_pc unchanged.
- FAULT exit: only via an aligned redirect or reset. fetch_enable is ignored in FAULT.
- Latency:
  - fetch_enable high at edge N (IDLE->RUN): first push at N+1; instr_valid=1 after N+1.
  - Aligned redirect at edge E: instr_valid=0 during E..E+1; target instruction valid after E+1.
- instr_valid/instr_data/instr_pc come directly from queue head registers. No combinational path from instr_ready to instr_valid.
- Queue head contents are stable while instr_valid=1 and instr_ready=0.
- Reset asserted mid-operation: immediate return to reset values; no partial push.

Test Plan:
- ROM[0..3]=AC 41 00 0A, ROM[4..7]=8C 43 00 0A, rest 0. Reset, fetch_enable=1, instr_ready=1:
  - instr_valid rises 2 cycles after enable.
  - Stream (pc, data): (0, AC41000A), (4, 8C43000A), (8, 00000000).
  - retired_count increments each cycle.
- Backpressure: instr_ready=0 for 5 cycles after first valid:
  - Queue fills to QUEUE_DEPTH=2; fetch_pc holds at 8; head stays (0, AC41000A).
  - On release, order 0, 4, 8 with no gaps or duplicates.
- Redirect to 4 while queue holds entries 8 and 12:
  - Queue flushed; instr_valid low one cycle; next delivered (4, 8C43000A) then (8, 0).
- Misaligned redirect to 6:
  - fault=1, fault_pc=6, instr_valid=0, no pushes for 10 cycles.
  - Redirect to 0 clears fault; (0, AC41000A) delivered.
- Wrap: redirect to FFFFFFFC:
  - Delivered pcs FFFFFFFC then 00000000, data AC41000A at pc 0.
- fetch_enable dropped with 2 queued, and separately reset_n pulsed mid-stream:
  - Queue drains, then no further pushes.
  - Reset returns all outputs to reset values within the same cycle.
